// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO writer/reader blocks: FSM encodings,
// the burst counter width and its saturating increment.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        WRITE = 2'd2
    } wr_state_e;

    localparam int BURST_CNT_W = 16;

    function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_wr_if.sv
// FIFO write-port bundle between a writer (master) and the FIFO (slave).
//
// Handshake: fifo_wr_en is the valid, ~full is the ready. A word in
// fifo_wr_data transfers on a rising edge where fifo_wr_en=1, full=0 and
// wr_rst_busy=0; empty comes from the read domain and is unsynchronized.
interface fifo_wr_if #(
    parameter int DATA_W = 8
) ();

    logic              empty;
    logic              wr_rst_busy;
    logic              almost_full;
    logic              full;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;

    modport master (
        input  empty,
        input  wr_rst_busy,
        input  almost_full,
        input  full,
        output fifo_wr_en,
        output fifo_wr_data
    );

    modport slave (
        output empty,
        output wr_rst_busy,
        output almost_full,
        output full,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
// Shared by the FIFO writer and reader.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic d0_q;
    logic d1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d0_q <= 1'b0;
            d1_q <= 1'b0;
        end else begin
            d0_q <= d_i;
            d1_q <= d0_q;
        end
    end

    assign q_o = d1_q;

endmodule

// File: rtl/fifo_wr.sv
// FIFO burst writer: waits DLY_CYCLES after the FIFO reports empty, then
// writes an incrementing pattern until almost_full ends the burst.
module fifo_wr
    import fifo_pkg::*;
#(
    parameter int DLY_CYCLES = 10,
    parameter int DATA_W     = 8
) (
    input  logic                   wr_clk,
    input  logic                   rst_n,
    fifo_wr_if.master              wr_if,
    output logic [BURST_CNT_W-1:0] burst_cnt,
    output logic                   ovf_err,
    output wr_state_e              state_o
);

    localparam int CNT_W = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DLY_CYCLES - 1);

    logic                   empty_d1;
    wr_state_e              state_q;
    logic [CNT_W-1:0]       dly_cnt_q;
    logic                   wr_en_q;
    logic [DATA_W-1:0]      data_q;
    logic [BURST_CNT_W-1:0] burst_cnt_q;
    logic                   ovf_q;

    sync_2ff u_empty_sync (
        .clk_i  (wr_clk),
        .rst_ni (rst_n),
        .d_i    (wr_if.empty),
        .q_o    (empty_d1)
    );

    // wr_rst_busy dominates everything: the word on the bus is not taken,
    // so data, burst count and overflow flag all hold.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dly_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            burst_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else if (wr_if.wr_rst_busy) begin
            wr_en_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (empty_d1) begin
                        state_q   <= DELAY;
                        dly_cnt_q <= '0;
                    end
                end
                DELAY: begin
                    if (dly_cnt_q == CNT_LAST) begin
                        state_q <= WRITE;
                        wr_en_q <= 1'b1;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_en_q && wr_if.full) begin
                        // Write into a full FIFO: abandon the burst, data not consumed.
                        ovf_q   <= 1'b1;
                        wr_en_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (wr_en_q) begin
                        data_q <= data_q + 1'b1;
                        if (wr_if.almost_full) begin
                            wr_en_q     <= 1'b0;
                            state_q     <= IDLE;
                            burst_cnt_q <= sat_inc(burst_cnt_q);
                        end
                    end
                end
                default: begin
                    wr_en_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_if.fifo_wr_en   = wr_en_q;
    assign wr_if.fifo_wr_data = data_q;
    assign burst_cnt          = burst_cnt_q;
    assign ovf_err            = ovf_q;
    assign state_o            = state_q;

endmodule
